// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: reset PC, BTB geometry and 2-bit counter encodings.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam int          BTB_IDX_W_DEF = 4;
    // Tag covers everything above the index; the two byte-offset bits are not stored.
    localparam int          TAG_W_DEF     = 32 - BTB_IDX_W_DEF - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_2bit.sv
// Direct-mapped branch target buffer with 2-bit counters; one lookup port, one train port.
// Latency: lookup is combinational; a train write is visible the cycle after its edge (no bypass).
// Backpressure: none; training is accepted every cycle upd_en is high.
//
// Ports: clk, rst_n (async active-low); lookup_pc -> hit/pred_taken/pred_target;
//        upd_en/upd_pc/upd_taken/upd_target train or allocate the entry at upd_pc.
module btb_2bit
    import fetch_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int TAG_W = 32 - IDX_W - 2;
    localparam int N     = 1 << IDX_W;

    logic [N-1:0]     valid_q;
    logic [1:0]       ctr_q [N];
    logic [TAG_W-1:0] tag_q [N];
    logic [31:0]      tgt_q [N];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // Byte-offset bits take no part in indexing or tagging.
    logic unused_offset;
    assign unused_offset = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];

    assign hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = hit && ctr_q[lk_idx][1];
    assign pred_target = tgt_q[lk_idx];
    assign up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                ctr_q[i] <= CTR_WNT;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_train(ctr_q[up_idx], upd_taken);
                if (upd_taken) begin
                    tgt_q[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                // A taken miss claims the slot, evicting any alias; not-taken misses are ignored.
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= upd_target;
                ctr_q[up_idx]   <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/if_fetch_predict.sv
// Instruction-fetch stage: PC register, next-PC selection and BTB-driven taken prediction.
// Latency: one cycle from next-PC selection (incl. EX redirect) to PC/imem_addr; IR is combinational.
// Backpressure: stall holds the PC; an EX redirect overrides stall and flushes IF/ID the same cycle.
//
// Ports: clk, reset (async active-low), stall; imem_addr/imem_rdata instruction memory;
//        IR/PC/PCPlus4/PredictJump/flush_ifid to IF/ID; ex_* resolution and training from EX.
module if_fetch_predict
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BTB_IDX_W = BTB_IDX_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        PredictJump,
    output logic        flush_ifid,
    input  logic        ex_update,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_redirect,
    input  logic [31:0] ex_next_pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        btb_hit;
    logic        btb_taken;
    logic [31:0] btb_target;

    logic unused_hit;
    assign unused_hit = btb_hit;

    btb_2bit #(
        .IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk         (clk),
        .rst_n       (reset),
        .lookup_pc   (pc_q),
        .hit         (btb_hit),
        .pred_taken  (btb_taken),
        .pred_target (btb_target),
        .upd_en      (ex_update),
        .upd_pc      (ex_pc),
        .upd_taken   (ex_taken),
        .upd_target  (ex_target)
    );

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect beats stall: the instruction being held is on the wrong path anyway.
    always_comb begin
        pc_next = pc_plus4;
        if (ex_redirect) begin
            pc_next = ex_next_pc;
        end else if (stall) begin
            pc_next = pc_q;
        end else if (btb_taken) begin
            pc_next = btb_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign imem_addr   = pc_q;
    assign IR          = imem_rdata;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign PredictJump = btb_taken;
    assign flush_ifid  = ex_redirect;

endmodule

// File: tb/tb_if_fetch_predict.sv
// Directed self-checking bench for if_fetch_predict.
// Latency: inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Backpressure: stall and redirect exercised directly from the stimulus sequence.
module tb_if_fetch_predict;

    localparam logic [31:0] K = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IR;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        PredictJump;
    logic        flush_ifid;
    logic        ex_update;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_redirect;
    logic [31:0] ex_next_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory: word content derived from its address.
    assign imem_rdata = imem_addr ^ K;

    if_fetch_predict dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .IR          (IR),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .PredictJump (PredictJump),
        .flush_ifid  (flush_ifid),
        .ex_update   (ex_update),
        .ex_pc       (ex_pc),
        .ex_taken    (ex_taken),
        .ex_target   (ex_target),
        .ex_redirect (ex_redirect),
        .ex_next_pc  (ex_next_pc)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] pc, input logic pj);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        check({tag, ".pc"},   PC,        pc);
        check({tag, ".addr"}, imem_addr, pc);
        check({tag, ".ir"},   IR,        pc ^ K);
        check({tag, ".pc4"},  PCPlus4,   pc4);
        check({tag, ".pj"},   {31'd0, PredictJump}, {31'd0, pj});
    endtask

    task automatic check_flush(input string tag, input logic exp);
        check(tag, {31'd0, flush_ifid}, {31'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        ex_update = 1'b1;
        ex_pc     = pc;
        ex_taken  = taken;
        ex_target = tgt;
    endtask

    task automatic redirect(input logic [31:0] npc);
        ex_redirect = 1'b1;
        ex_next_pc  = npc;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0;
        ex_update = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
        ex_redirect = 1'b0; ex_next_pc = '0;

        // Reset state; flush follows ex_redirect even in reset; PC ignores the edge.
        #2;
        expect_fetch("rst", 32'h0, 1'b0);
        redirect(32'h80);
        #1 check_flush("rst_flush1", 1'b1);
        step();
        expect_fetch("rst_hold", 32'h0, 1'b0);
        ex_redirect = 1'b0;
        #1 check_flush("rst_flush0", 1'b0);
        reset = 1'b1;
        #1 expect_fetch("t1_0", 32'h0, 1'b0);

        // 1: sequential fetch with empty BTB.
        step(); expect_fetch("t1_4", 32'h4, 1'b0);
        step(); expect_fetch("t1_8", 32'h8, 1'b0);
        step(); expect_fetch("t1_c", 32'hC, 1'b0);

        // 2: allocate at 0x10 on the edge that brings fetch to 0x10.
        train(32'h10, 1'b1, 32'h40);
        step(); ex_update = 1'b0;
        expect_fetch("t2_hit", 32'h10, 1'b1);
        step(); expect_fetch("t2_tgt", 32'h40, 1'b0);

        // 3: redirect back, then two not-taken updates while stalled (10->01->00).
        redirect(32'h10);
        check_flush("t3_flush", 1'b1);
        step(); ex_redirect = 1'b0;
        check_flush("t3_noflush", 1'b0);
        expect_fetch("t3_wt", 32'h10, 1'b1);
        stall = 1'b1;
        train(32'h10, 1'b0, 32'h0);
        step(); expect_fetch("t3_wnt", 32'h10, 1'b0);
        step(); expect_fetch("t3_snt", 32'h10, 1'b0);
        ex_update = 1'b0; stall = 1'b0;
        step(); expect_fetch("t3_seq", 32'h14, 1'b0);

        // 3b: counter saturation at both ends.
        stall = 1'b1;
        train(32'h10, 1'b0, 32'h0);
        redirect(32'h10);
        step(); ex_redirect = 1'b0; ex_update = 1'b0;
        expect_fetch("sat_lo", 32'h10, 1'b0);
        train(32'h10, 1'b1, 32'h40);
        step(); expect_fetch("up_01", 32'h10, 1'b0);
        step(); expect_fetch("up_10", 32'h10, 1'b1);
        step(); expect_fetch("up_11", 32'h10, 1'b1);
        step(); expect_fetch("up_11s", 32'h10, 1'b1);
        ex_taken = 1'b0;
        step(); expect_fetch("dn_10", 32'h10, 1'b1);
        step(); expect_fetch("sat_hi", 32'h10, 1'b0);
        ex_update = 1'b0; stall = 1'b0;
        step(); expect_fetch("t3b_seq", 32'h14, 1'b0);

        // 4: stall holds; redirect overrides stall.
        stall = 1'b1;
        step(); expect_fetch("t4_hold", 32'h14, 1'b0);
        redirect(32'h80);
        check_flush("t4_flush", 1'b1);
        step(); ex_redirect = 1'b0; stall = 1'b0;
        check_flush("t4_noflush", 1'b0);
        expect_fetch("t4_redir", 32'h80, 1'b0);

        // 5: alias eviction, not-taken miss ignored, PC wrap.
        train(32'h10, 1'b1, 32'h40);
        step(); expect_fetch("t5_84", 32'h84, 1'b0);
        train(32'h50, 1'b1, 32'hC0);
        step(); expect_fetch("t5_88", 32'h88, 1'b0);
        train(32'h90, 1'b0, 32'h0);
        step(); expect_fetch("t5_8c", 32'h8C, 1'b0);
        ex_update = 1'b0;
        redirect(32'h10);
        step(); expect_fetch("t5_evict", 32'h10, 1'b0);
        ex_redirect = 1'b0;
        step(); expect_fetch("t5_14", 32'h14, 1'b0);
        redirect(32'h50);
        step(); expect_fetch("t5_alias", 32'h50, 1'b1);
        ex_redirect = 1'b0;
        step(); expect_fetch("t5_c0", 32'hC0, 1'b0);
        redirect(32'hFFFF_FFFC);
        step(); expect_fetch("t5_top", 32'hFFFF_FFFC, 1'b0);
        ex_redirect = 1'b0;
        step(); expect_fetch("t5_wrap", 32'h0, 1'b0);

        // 6: reset mid-operation with stall and a pending update.
        step(); expect_fetch("t6_4", 32'h4, 1'b0);
        stall = 1'b1;
        train(32'h4, 1'b1, 32'h100);
        #2 reset = 1'b0;
        #1 expect_fetch("t6_async", 32'h0, 1'b0);
        step(); expect_fetch("t6_held", 32'h0, 1'b0);
        ex_update = 1'b0; stall = 1'b0;
        reset = 1'b1;
        #1 expect_fetch("t6_rel", 32'h0, 1'b0);
        redirect(32'h50);
        step(); expect_fetch("t6_cleared", 32'h50, 1'b0);
        redirect(32'h4);
        step(); expect_fetch("t6_noupd", 32'h4, 1'b0);
        ex_redirect = 1'b0;
        step(); expect_fetch("t6_seq", 32'h8, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
